pipeline_control_unit: RTL and testbench
========================================

PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 The block SHALL have parameter NB_COUNTER, default 32, giving the width of each event counter.
REQ-002 The block SHALL have parameter RESET_BUBBLES, default 2, giving the number of post-reset bubble cycles (legal 1..15).
REQ-003 The block SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1, the reset: asynchronous and active-low.
REQ-005 The block SHALL have port i_load_hazard, input, 1, load-use hazard from hazard detection.
REQ-006 The block SHALL have port i_branch_hazard, input, 1, taken-branch hazard from hazard detection.
REQ-007 The block SHALL have port i_imem_ready, input, 1, instruction fetch data valid this cycle.
REQ-008 The block SHALL have port i_halt, input, 1, halt request (ecall/ebreak decoded in ID).
REQ-009 The block SHALL have port i_resume, input, 1, resume request while halted.
REQ-010 The block SHALL have port i_cnt_clr, input, 1, synchronous clear of both counters.
REQ-011 The block SHALL have ports o_pc_we, o_if_id_we, o_if_id_flush and o_id_ex_flush, each an output of width 1, acting as PC write enable, IF/ID write enable, IF/ID bubble insert and ID/EX bubble insert.
REQ-012 The block SHALL have port o_state, output, 2, current FSM state encoding.
REQ-013 The block SHALL have ports o_stall_count and o_flush_count, each an output of width NB_COUNTER, counting load-stall cycles and branch-flush cycles.

Function
REQ-014 The FSM SHALL have states INIT=2'd0, RUN=2'd1 and HALT=2'd2; 2'd3 is illegal and SHALL return to INIT on the next edge.
REQ-015 In INIT, o_pc_we=0, o_if_id_we=0, o_if_id_flush=1 and o_id_ex_flush=1; a bubble counter SHALL move to RUN after exactly RESET_BUBBLES cycles.
REQ-016 Control outputs SHALL be combinational from state and current inputs (zero-cycle latency), using priority branch > load > halt > imem wait > normal.
REQ-017 RUN with i_branch_hazard=1: pc_we=1, if_id_we=1, if_id_flush=1, id_ex_flush=1, and flush_count increments; simultaneous load or halt is ignored.
REQ-018 RUN with i_load_hazard=1 and no branch: pc_we=0, if_id_we=0, if_id_flush=0, id_ex_flush=1, and stall_count increments.
REQ-019 RUN with i_halt=1 and no branch or load: ID/EX bubble inserted, pc_we=0, if_id_we=0, and the state moves to HALT next edge.
REQ-020 RUN with i_imem_ready=0 and no other event: pc_we=0, if_id_we=1, if_id_flush=1, id_ex_flush=0, and no counter changes.
REQ-021 RUN with no event: pc_we=1, if_id_we=1, and both flushes 0.
REQ-022 In HALT, pc_we=0, if_id_we=0, id_ex_flush=1 and if_id_flush=0, with hazard inputs ignored; i_resume=1 SHALL return the state to RUN next edge.
REQ-023 Counters SHALL saturate at all-ones with no wrap.
REQ-024 i_cnt_clr SHALL clear both counters to 0 at the edge, taking precedence over an increment in the same cycle.

Reset
REQ-025 While i_rst_n=0, state=INIT, the bubble counter=0, both counters=0 and the outputs SHALL take INIT values, all immediately and asynchronously.
REQ-026 Reset asserted mid-HALT or mid-stall SHALL abort the operation; after deassertion the full RESET_BUBBLES INIT sequence SHALL replay.

Structure
REQ-027 The state enum and the encoding widths SHALL live in the shared package riscv_pkg, alongside NB_OPERAND.
REQ-028 One sub-module, sat_counter (parameter NB, with inc, clr and value ports), SHALL be instantiated twice for the two counters; the FSM and output decode are inline.

Verification
REQ-029 Reset release, no events: o_state=0 for 2 cycles with both flushes 1 and pc_we=0, then o_state=1 with pc_we=1.
REQ-030 RUN, i_load_hazard=1 for 3 cycles: pc_we=0, if_id_we=0 and id_ex_flush=1 each cycle, ending with stall_count=3.
REQ-031 RUN, load and branch high together for 1 cycle: if_id_flush=1, id_ex_flush=1, pc_we=1, flush_count+1, stall_count unchanged.
REQ-032 RUN, i_halt pulse, then idle 5 cycles, then i_resume: o_state=2 for 6 cycles and returns to 1, with pc_we=0 throughout HALT.
REQ-033 NB_COUNTER=4, 20 load-stall cycles: stall_count holds at 15; i_cnt_clr together with a load stall gives 0.
REQ-034 i_rst_n dropped during HALT: outputs go to INIT values without waiting for a clock edge, and the counters read 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the RISC-V core: operand width, pipeline-control FSM
// states and the bundle of pipeline-register enables driven by the control unit.
package riscv_pkg;

    localparam int NB_OPERAND = 32;
    localparam int NB_STATE   = 2;
    localparam int NB_BUBBLE  = 4;

    typedef enum logic [NB_STATE-1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALT    = 2'd2,
        ST_ILLEGAL = 2'd3
    } pcu_state_t;

    // One field per pipeline-register control line.
    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_flush;
    } pcu_ctrl_t;

    localparam pcu_ctrl_t CTRL_INIT   = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b1, id_ex_flush: 1'b1};
    localparam pcu_ctrl_t CTRL_BRANCH = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1};
    localparam pcu_ctrl_t CTRL_LOAD   = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b1};
    localparam pcu_ctrl_t CTRL_HALT   = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b1};
    localparam pcu_ctrl_t CTRL_IWAIT  = '{pc_we: 1'b0, if_id_we: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b0};
    localparam pcu_ctrl_t CTRL_NORMAL = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; a clear wins
// over an increment in the same cycle.
module sat_counter #(
    parameter int NB = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [NB-1:0] value
);

    logic at_max;

    assign at_max = &value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && !at_max) begin
            value <= value + NB'(1);
        end
    end

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline control for the 5-stage core: post-reset bubbles, hazard stalls and
// flushes, halt/resume, plus saturating load-stall and branch-flush counters.
module pipeline_control_unit
    import riscv_pkg::*;
#(
    parameter int NB_COUNTER    = 32,
    parameter int RESET_BUBBLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load_hazard,
    input  logic                  i_branch_hazard,
    input  logic                  i_imem_ready,
    input  logic                  i_halt,
    input  logic                  i_resume,
    input  logic                  i_cnt_clr,
    output logic                  o_pc_we,
    output logic                  o_if_id_we,
    output logic                  o_if_id_flush,
    output logic                  o_id_ex_flush,
    output logic [NB_STATE-1:0]   o_state,
    output logic [NB_COUNTER-1:0] o_stall_count,
    output logic [NB_COUNTER-1:0] o_flush_count
);

    localparam logic [NB_BUBBLE-1:0] LAST_BUBBLE = NB_BUBBLE'(RESET_BUBBLES - 1);

    pcu_state_t           state_q, state_d;
    logic [NB_BUBBLE-1:0] bubble_q, bubble_d;
    pcu_ctrl_t            ctrl;
    logic                 stall_inc;
    logic                 flush_inc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_INIT;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            bubble_q <= bubble_d;
        end
    end

    // i_imem_ready is a plain valid with no back-pressure: when low the PC holds
    // and IF/ID is refilled with a bubble until the fetch data arrives.
    always_comb begin
        state_d   = state_q;
        bubble_d  = '0;
        ctrl      = CTRL_INIT;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            ST_INIT: begin
                ctrl = CTRL_INIT;
                if (bubble_q == LAST_BUBBLE) begin
                    state_d = ST_RUN;
                end else begin
                    bubble_d = bubble_q + NB_BUBBLE'(1);
                end
            end
            ST_RUN: begin
                // Fixed priority: branch > load > halt > fetch wait > normal.
                if (i_branch_hazard) begin
                    ctrl      = CTRL_BRANCH;
                    flush_inc = 1'b1;
                end else if (i_load_hazard) begin
                    ctrl      = CTRL_LOAD;
                    stall_inc = 1'b1;
                end else if (i_halt) begin
                    ctrl    = CTRL_HALT;
                    state_d = ST_HALT;
                end else if (!i_imem_ready) begin
                    ctrl = CTRL_IWAIT;
                end else begin
                    ctrl = CTRL_NORMAL;
                end
            end
            ST_HALT: begin
                ctrl = CTRL_HALT;
                if (i_resume) begin
                    state_d = ST_RUN;
                end
            end
            ST_ILLEGAL: begin
                ctrl    = CTRL_INIT;
                state_d = ST_INIT;
            end
            default: begin
                ctrl    = CTRL_INIT;
                state_d = ST_INIT;
            end
        endcase
    end

    assign o_pc_we       = ctrl.pc_we;
    assign o_if_id_we    = ctrl.if_id_we;
    assign o_if_id_flush = ctrl.if_id_flush;
    assign o_id_ex_flush = ctrl.id_ex_flush;
    assign o_state       = state_q;

    sat_counter #(
        .NB (NB_COUNTER)
    ) u_stall_counter (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (stall_inc),
        .clr   (i_cnt_clr),
        .value (o_stall_count)
    );

    sat_counter #(
        .NB (NB_COUNTER)
    ) u_flush_counter (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (flush_inc),
        .clr   (i_cnt_clr),
        .value (o_flush_count)
    );

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: a 32-bit and a 4-bit-counter instance share
// stimulus and are checked every cycle against a rule-level reference model.
module tb_pipeline_control_unit;

    localparam int BUBBLES = 2;

    // ---------------- clock / reset ----------------
    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic i_rst_n;
    logic i_load_hazard, i_branch_hazard, i_imem_ready, i_halt, i_resume, i_cnt_clr;

    logic        a_pc_we, a_if_id_we, a_if_id_flush, a_id_ex_flush;
    logic [1:0]  a_state;
    logic [31:0] a_stall, a_flush;
    logic        b_pc_we, b_if_id_we, b_if_id_flush, b_id_ex_flush;
    logic [1:0]  b_state;
    logic [3:0]  b_stall, b_flush;

    pipeline_control_unit #(.NB_COUNTER(32), .RESET_BUBBLES(BUBBLES)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_load_hazard(i_load_hazard), .i_branch_hazard(i_branch_hazard),
        .i_imem_ready(i_imem_ready), .i_halt(i_halt), .i_resume(i_resume),
        .i_cnt_clr(i_cnt_clr),
        .o_pc_we(a_pc_we), .o_if_id_we(a_if_id_we),
        .o_if_id_flush(a_if_id_flush), .o_id_ex_flush(a_id_ex_flush),
        .o_state(a_state), .o_stall_count(a_stall), .o_flush_count(a_flush)
    );

    pipeline_control_unit #(.NB_COUNTER(4), .RESET_BUBBLES(BUBBLES)) dut4 (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_load_hazard(i_load_hazard), .i_branch_hazard(i_branch_hazard),
        .i_imem_ready(i_imem_ready), .i_halt(i_halt), .i_resume(i_resume),
        .i_cnt_clr(i_cnt_clr),
        .o_pc_we(b_pc_we), .o_if_id_we(b_if_id_we),
        .o_if_id_flush(b_if_id_flush), .o_id_ex_flush(b_id_ex_flush),
        .o_state(b_state), .o_stall_count(b_stall), .o_flush_count(b_flush)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_tests = 0;
    int n_fail  = 0;

    // mode: 0 = bubbling after reset, 1 = running, 2 = halted
    int     m_mode;
    int     m_left;
    longint m_stall;
    longint m_flush;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // {pc_we, if_id_we, if_id_flush, id_ex_flush}
    function automatic logic [3:0] exp_ctrl();
        if (m_mode == 0) return 4'b0011;
        if (m_mode == 2) return 4'b0001;
        if (i_branch_hazard) return 4'b1111;
        if (i_load_hazard) return 4'b0001;
        if (i_halt) return 4'b0001;
        if (!i_imem_ready) return 4'b0110;
        return 4'b1100;
    endfunction

    function automatic longint sat(input longint v, input int bits);
        longint top;
        top = (longint'(1) << bits) - 1;
        return (v > top) ? top : v;
    endfunction

    task automatic model_edge();
        case (m_mode)
            0: begin
                m_left--;
                if (m_left == 0) m_mode = 1;
            end
            1: begin
                if (i_branch_hazard) m_flush++;
                else if (i_load_hazard) m_stall++;
                else if (i_halt) m_mode = 2;
            end
            2: if (i_resume) m_mode = 1;
            default: m_mode = 0;
        endcase
        if (i_cnt_clr) begin
            m_stall = 0;
            m_flush = 0;
        end
    endtask

    task automatic check_all();
        check("state", 64'(a_state), 64'(m_mode));
        check("state4", 64'(b_state), 64'(m_mode));
        check("ctrl", 64'({a_pc_we, a_if_id_we, a_if_id_flush, a_id_ex_flush}), 64'(exp_ctrl()));
        check("ctrl4", 64'({b_pc_we, b_if_id_we, b_if_id_flush, b_id_ex_flush}), 64'(exp_ctrl()));
        check("stall", 64'(a_stall), 64'(sat(m_stall, 32)));
        check("flush", 64'(a_flush), 64'(sat(m_flush, 32)));
        check("stall4", 64'(b_stall), 64'(sat(m_stall, 4)));
        check("flush4", 64'(b_flush), 64'(sat(m_flush, 4)));
    endtask

    // ---------------- driver tasks ----------------
    // Entered and left at a falling edge; inputs are already applied.
    task automatic cycle();
        #1 check_all();
        @(posedge i_clk);
        if (i_rst_n) model_edge();
        @(negedge i_clk);
    endtask

    task automatic drive(input logic br, input logic ld, input logic hl,
                         input logic rs, input logic im, input logic cl);
        i_branch_hazard = br;
        i_load_hazard   = ld;
        i_halt          = hl;
        i_resume        = rs;
        i_imem_ready    = im;
        i_cnt_clr       = cl;
        cycle();
    endtask

    // Drops reset mid-cycle and checks the outputs change with no clock edge.
    task automatic do_reset();
        #2 i_rst_n = 1'b0;
        #1;
        check("rst_ctrl", 64'({a_pc_we, a_if_id_we, a_if_id_flush, a_id_ex_flush}), 64'h3);
        check("rst_ctrl4", 64'({b_pc_we, b_if_id_we, b_if_id_flush, b_id_ex_flush}), 64'h3);
        check("rst_state", 64'(a_state), 64'h0);
        check("rst_stall", 64'(a_stall), 64'h0);
        check("rst_flush", 64'(a_flush), 64'h0);
        check("rst_cnt4", 64'({b_stall, b_flush}), 64'h0);
        m_mode  = 0;
        m_left  = BUBBLES;
        m_stall = 0;
        m_flush = 0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int halt_cycles;
        i_rst_n = 1'b0;
        i_branch_hazard = 1'b0; i_load_hazard = 1'b0; i_halt = 1'b0;
        i_resume = 1'b0; i_imem_ready = 1'b1; i_cnt_clr = 1'b0;
        m_mode = 0; m_left = BUBBLES; m_stall = 0; m_flush = 0;
        @(negedge i_clk);
        do_reset();

        // Reset release: two INIT bubbles, then RUN.
        repeat (3) drive(0, 0, 0, 0, 1, 0);
        check("run_after_bubbles", 64'(a_state), 64'h1);

        // Three load-use stalls.
        repeat (3) drive(0, 1, 0, 0, 1, 0);
        check("stall_after_3", 64'(a_stall), 64'd3);

        // Branch beats load.
        drive(1, 1, 0, 0, 1, 0);
        check("branch_wins_flush", 64'(a_flush), 64'd1);
        check("branch_wins_stall", 64'(a_stall), 64'd3);

        // Fetch wait and halt with hazards idle.
        drive(0, 0, 0, 0, 0, 0);
        halt_cycles = 0;
        drive(0, 0, 1, 0, 1, 0);
        if (a_state == 2'd2) halt_cycles++;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 1, 0);
            if (a_state == 2'd2) halt_cycles++;
        end
        drive(0, 0, 0, 1, 1, 0);
        check("halt_cycles", 64'(halt_cycles), 64'd6);
        check("resumed", 64'(a_state), 64'h1);

        // Saturation of the 4-bit counter, then clear beats a stall.
        repeat (20) drive(0, 1, 0, 0, 1, 0);
        check("stall4_saturated", 64'(b_stall), 64'd15);
        check("stall32_count", 64'(a_stall), 64'd23);
        drive(0, 1, 0, 0, 1, 1);
        check("clr_over_inc", 64'(a_stall), 64'd0);
        check("clr_over_inc4", 64'(b_stall), 64'd0);

        // Reset in the middle of HALT replays the bubble sequence.
        drive(1, 0, 0, 0, 1, 0);
        drive(0, 0, 1, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        do_reset();
        repeat (3) drive(0, 0, 0, 0, 1, 0);

        // Reset in the middle of a stall run.
        drive(0, 1, 0, 0, 1, 0);
        do_reset();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 99) < 15,
                      $urandom_range(0, 99) < 30,
                      $urandom_range(0, 99) < 6,
                      $urandom_range(0, 99) < 30,
                      $urandom_range(0, 99) < 80,
                      $urandom_range(0, 99) < 3);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
